// File: rtl/sipo_frame_if.sv
// Bundle of the serial-in side and the valid/ready word output of sipo_frame_receiver.
// The receiver uses the slave modport; whoever drives the serial stream and consumes words uses master.
interface sipo_frame_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             ser_in;
    logic             ser_en;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output start, ser_in, ser_en, out_ready,
        input  out_data, out_valid, busy, overrun, parity_err
    );

    modport slave (
        input  start, ser_in, ser_en, out_ready,
        output out_data, out_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/sipo_frame_receiver.sv
// Reassembles LSB-first serial frames into WIDTH-bit words held behind a valid/ready handshake.
// Optional even-parity trailer bit is enabled by defining PARITY_CHECK_EN.
module sipo_frame_receiver #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    sipo_frame_if.slave  bus
);
`ifdef PARITY_CHECK_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BITS - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             frame_done;
    logic             consume;
    logic [WIDTH-1:0] word;

`ifdef PARITY_CHECK_EN
    // Full-width shifter: the parity bit arrives after the data and is never shifted in.
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_acc_q, par_acc_d;
    logic             perr_q, perr_d;
    logic             word_perr;
`else
    // Only WIDTH-1 bits are stored; the final bit is taken straight from ser_in.
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] shift_in;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
`ifdef PARITY_CHECK_EN
        par_acc_d  = par_acc_q;
        word       = shift_q;
        word_perr  = par_acc_q ^ bus.ser_in;
`else
        shift_in   = {bus.ser_in, shift_q};
        word       = shift_in;
`endif
        case (state_q)
            IDLE: begin
                // ser_in is not yet meaningful in the start cycle, so nothing is sampled
                if (bus.start) begin
                    state_d = RECV;
                    count_d = '0;
`ifdef PARITY_CHECK_EN
                    par_acc_d = 1'b0;
`endif
                end
            end
            RECV: begin
                if (bus.start) begin
                    count_d = '0;
`ifdef PARITY_CHECK_EN
                    par_acc_d = 1'b0;
`endif
                end else if (bus.ser_en) begin
                    count_d = count_q + CW'(1);
`ifdef PARITY_CHECK_EN
                    par_acc_d = par_acc_q ^ bus.ser_in;
                    if (count_q < CW'(WIDTH)) begin
                        shift_d = {bus.ser_in, shift_q[WIDTH-1:1]};
                    end
`else
                    shift_d = shift_in[WIDTH-1:1];
`endif
                    if (count_q == LAST_IDX) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output holding register: a completing word may replace one that is consumed on the same edge.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef PARITY_CHECK_EN
        perr_d    = perr_q;
`endif
        consume   = valid_q && bus.out_ready;
        if (frame_done) begin
            if (!valid_q || consume) begin
                data_d  = word;
                valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                perr_d  = word_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_acc_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
            par_acc_q <= par_acc_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed and randomized stimulus for sipo_frame_receiver, checked every cycle against a
// queue-based model of frames, words and the output handshake.
module tb_sipo_frame_receiver;
    localparam int W = 4;
`ifdef PARITY_CHECK_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    sipo_frame_if #(.WIDTH(W)) bus ();

    sipo_frame_receiver #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model: a frame is "open" after start; collected bits are kept in a queue.
    bit           m_active;
    bit           m_rx[$];
    logic [W-1:0] m_data;
    bit           m_valid, m_busy, m_overrun, m_perr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_edge(input bit rst, input bit st, input bit si, input bit se, input bit rdy);
        bit           done;
        bit           consume;
        logic [W-1:0] w;
        bit           perr;
        done = 1'b0;
        if (rst) begin
            m_active = 0; m_rx.delete(); m_data = '0;
            m_valid = 0; m_busy = 0; m_overrun = 0; m_perr = 0;
            return;
        end
        if (m_active) begin
            if (st) m_rx.delete();
            else if (se) begin
                m_rx.push_back(si);
                if (m_rx.size() == FB) begin
                    done = 1'b1;
                    m_active = 0;
                end
            end
        end else if (st) begin
            m_active = 1;
            m_rx.delete();
        end
        consume = m_valid && rdy;
        if (done) begin
            w = '0;
            perr = 1'b0;
            for (int i = 0; i < W; i++) w[i] = m_rx[i];
`ifdef PARITY_CHECK_EN
            for (int i = 0; i < FB; i++) perr = perr ^ m_rx[i];
`endif
            if (!m_valid || consume) begin
                m_data = w; m_valid = 1; m_perr = perr;
                $display("word accepted: data=%0h parity_err=%0b at %0t", w, perr, $time);
            end else begin
                m_overrun = 1;
                $display("word dropped (overrun): data=%0h at %0t", w, $time);
            end
        end else if (consume) begin
            m_valid = 0;
        end
        m_busy = m_active;
    endtask

    task automatic step(input bit rst, input bit st, input bit si, input bit se, input bit rdy);
        reset = rst; bus.start = st; bus.ser_in = si; bus.ser_en = se; bus.out_ready = rdy;
        @(posedge clk);
        model_edge(rst, st, si, se, rdy);
        #1;
        check("out_data",   32'(bus.out_data),   32'(m_data));
        check("out_valid",  32'(bus.out_valid),  32'(m_valid));
        check("busy",       32'(bus.busy),       32'(m_busy));
        check("overrun",    32'(bus.overrun),    32'(m_overrun));
        check("parity_err", 32'(bus.parity_err), 32'(m_perr));
    endtask

    // start strobe, then every frame bit back to back; out_ready only on the last bit
    task automatic send_word(input logic [W-1:0] w, input bit pflip, input bit rdy_last);
        bit b;
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < FB; i++) begin
            b = (i < W) ? w[i] : ((^w) ^ pflip);
            step(0, 0, b, 1, (i == FB - 1) ? rdy_last : 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] gap_word;
        m_active = 0; m_data = '0; m_valid = 0; m_busy = 0; m_overrun = 0; m_perr = 0;
        bus.start = 0; bus.ser_in = 0; bus.ser_en = 0; bus.out_ready = 0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_out_data", 32'(bus.out_data), 32'h0);
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);

        // basic frame 1,0,1,1
        send_word(4'b1101, 0, 0);
        check("basic_word", 32'(bus.out_data), 32'hD);
        step(0, 0, 0, 0, 1);

        // same frame with a 2-cycle gap between bits 2 and 3
        gap_word = 4'b1101;
        step(0, 1, 0, 0, 0);
        step(0, 0, gap_word[0], 1, 0);
        step(0, 0, gap_word[1], 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 2; i < FB; i++) step(0, 0, (i < W) ? gap_word[i] : ^gap_word, 1, 0);
        check("gap_word", 32'(bus.out_data), 32'hD);

        // overrun: A held, 5 dropped, then consumed
        step(1, 0, 0, 0, 0);
        send_word(4'hA, 0, 0);
        send_word(4'h5, 0, 0);
        check("overrun_hold", 32'(bus.out_data), 32'hA);
        check("overrun_flag", 32'(bus.overrun), 32'h1);
        step(0, 0, 0, 0, 1);
        check("overrun_sticky", 32'(bus.overrun), 32'h1);

        // replace on the same edge the held word is consumed
        step(1, 0, 0, 0, 0);
        send_word(4'h3, 0, 0);
        send_word(4'hC, 0, 1);
        check("replace_word", 32'(bus.out_data), 32'hC);
        check("replace_no_overrun", 32'(bus.overrun), 32'h0);
        step(0, 0, 0, 0, 1);

        // restart after 2 bits
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        send_word(4'b0110, 0, 0);
        check("restart_word", 32'(bus.out_data), 32'h6);
        step(0, 0, 0, 0, 1);

        // reset after 3 bits: nothing emitted
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < FB + 2; i++) step(0, 0, 1, 1, 0);
        check("reset_mid_valid", 32'(bus.out_valid), 32'h0);

`ifdef PARITY_CHECK_EN
        send_word(4'b0011, 0, 0);
        check("parity_ok", 32'(bus.parity_err), 32'h0);
        step(0, 0, 0, 0, 1);
        send_word(4'b0011, 1, 0);
        check("parity_bad", 32'(bus.parity_err), 32'h1);
        step(0, 0, 0, 0, 1);
`endif

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 19) == 0,
                 1'($urandom),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
- Downstream consumer of the 4-bit PISO shift register's serial output (Q).
- Reassembles LSB-first serial frames into parallel words.
- Holds each word in an output register with a valid/ready handshake.
- Flags overrun when a new word completes before the previous one is taken.

Parameters:
WIDTH, 4, data bits per frame; must be >= 2

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  frame-start strobe; asserted in the same cycle the upstream PISO sees load=1
ser_in  input  1  serial data, driven by upstream Q; LSB first
ser_en  input  1  bit-valid qualifier; ser_in is sampled only when ser_en=1 in RECV
out_data  output  WIDTH  assembled word, held stable while out_valid=1
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts the word when out_valid && out_ready
busy  output  1  1 while in RECV
overrun  output  1  sticky flag: a completed word was dropped
parity_err  output  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (synchronous, active-high; clk and reset names as used across the codebase):
  - state=IDLE, bit count=0, shift reg=0.
  - out_data=0, out_valid=0, busy=0, overrun=0, parity_err=0.
  - Reset mid-frame discards the partial word and any held word.
- FSM states: IDLE and RECV.
  - IDLE: start=1 -> RECV, count cleared. ser_in is ignored in the start cycle, because upstream Q shows the new D[0] only after the load edge.
  - RECV: each cycle with ser_en=1:
    - shift reg <= {ser_in, shift[WIDTH-1:1]}, so the first bit lands in bit 0 after WIDTH shifts.
    - count increments.
    - Cycles with ser_en=0 hold state and count; gaps are allowed.
  - RECV: the sample that makes count reach FRAME_BITS completes the frame -> IDLE next cycle. FRAME_BITS=WIDTH, or WIDTH+1 with the Optional Feature.
  - start=1 while in RECV: abort the partial frame, clear count, stay in RECV (restart). start has priority over a coincident ser_en sample.
- Completion (registered):
  - out_data takes the assembled word. The final bit is included, so out_data = {ser_in_last, shift[WIDTH-1:1]}.
  - out_valid=1 in the cycle after the last sample.
  - Latency: last data sample edge -> out_valid high at that same edge, visible the next cycle.
- Handshake:
  - A word is consumed on a clock edge where out_valid=1 and out_ready=1.
  - out_valid clears on consumption unless a new word completes on the same edge. In that case the new word loads, out_valid stays 1, and there is no overrun.
  - Completion while out_valid=1 and out_ready=0: the new word is dropped, out_data is unchanged, overrun<=1.
  - overrun clears only on reset.
  - out_data is stable while out_valid=1.
- busy = (state==RECV), registered.
- Counter width: $clog2(WIDTH+2). No wrap; count never exceeds FRAME_BITS.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - Frame is WIDTH data bits followed by one even-parity bit (XOR of data and parity bits = 0).
  - The parity bit is sampled via ser_en like a data bit and is not stored in out_data.
  - parity_err is registered alongside out_data: 1 if the parity check fails, updated only when a word is accepted into out_data.
  - Dropped (overrun) words do not update parity_err.
  - parity_err resets to 0.
- Undefined: frame is WIDTH bits; parity_err is constant 0.

Test Plan:
- Reset, then start, then ser_en=1 for 4 cycles with ser_in=1,0,1,1 -> out_data=4'b1101, out_valid=1 one cycle after the 4th sample, busy high for 4 cycles, overrun=0.
- Same frame with ser_en low for 2 cycles between bits 2 and 3 -> out_data=4'b1101; completion delayed by 2 cycles.
- Frame 4'hA left unconsumed (out_ready=0), then frame 4'h5 completes -> out_data stays 4'hA, overrun=1. Then out_ready=1 -> out_valid=0; overrun stays 1.
- Frame 4'h3 held, out_ready=1 on the same edge frame 4'hC completes -> out_data=4'hC, out_valid stays 1, overrun=0.
- start after 2 bits of a frame, then 4 bits 0,1,1,0 -> out_data=4'b0110 and nothing else emitted. Separately: reset asserted after 3 bits -> all outputs 0 and no word emitted.
- PARITY_CHECK_EN defined: data 1,1,0,0 with parity bit 0 -> out_data=4'b0011, parity_err=0. Parity bit 1 -> parity_err=1.
